// File: rtl/imm_decode_ctrl.sv
// ID-stage immediate controller: opcode decode for the external signExtend, ID/EX register with
// valid/ready, stall and flush. Optional prefix-immediate sequencing under `IMM_PREFIX_EN`.
module imm_decode_ctrl #(
  parameter int         INSTR_W = 16,
  parameter logic [3:0] PFX_OPC = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic [1:0]         se_select,
  output logic [INSTR_W-1:0] se_in,
  input  logic [INSTR_W-1:0] se_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_imm,
  output logic               out_imm_used,
  output logic               out_illegal
);

  logic [3:0]         w_opc;
  logic [1:0]         w_sel;
  logic               w_used;
  logic               w_illegal;
  logic               w_accept;
  logic               w_beat;
  logic [INSTR_W-1:0] w_imm_next;

  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [INSTR_W-1:0] r_out_imm;
  logic               r_out_imm_used;
  logic               r_out_illegal;

  assign w_opc = in_instr[INSTR_W-1 -: 4];

`ifdef IMM_PREFIX_EN
  logic w_is_pfx;
`endif

  always_comb begin
    w_sel     = 2'b00;
    w_used    = 1'b0;
    w_illegal = 1'b0;
`ifdef IMM_PREFIX_EN
    w_is_pfx  = 1'b0;
`endif
    case (w_opc)
      4'h8, 4'h9: begin w_sel = 2'b01; w_used = 1'b1; end
      4'hA, 4'hB: begin w_sel = 2'b00; w_used = 1'b1; end
      4'hC, 4'hD: begin w_sel = 2'b10; w_used = 1'b1; end
      4'hE:       begin w_sel = 2'b11; w_used = 1'b1; end
      default:    ;
    endcase
    if (w_opc == PFX_OPC) begin
      w_sel  = 2'b00;
      w_used = 1'b0;
`ifdef IMM_PREFIX_EN
      w_is_pfx = 1'b1;
`else
      w_illegal = 1'b1;
`endif
    end
  end

  assign se_select = w_sel;
  assign se_in     = in_instr;

  assign in_ready = rst_n && !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef IMM_PREFIX_EN
  // state  | meaning
  // S_IDLE | no prefix pending, immediates come from signExtend
  // S_PFX  | prefix seen, r_pfx supplies the upper immediate byte for the next imm-type instr
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PFX  = 1'b1;

  logic [0:0] r_state;
  logic [7:0] r_pfx;

  assign w_beat     = w_accept && !w_is_pfx;
  assign w_imm_next = !w_used           ? '0 :
                      (r_state == S_PFX) ? {r_pfx, in_instr[7:0]} : se_out;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state <= S_IDLE;
      r_pfx   <= 8'h00;
    end else if (w_accept) begin
      if (w_is_pfx) begin
        r_state <= S_PFX;
        r_pfx   <= in_instr[7:0];
      end else begin
        r_state <= S_IDLE;
        r_pfx   <= 8'h00;
      end
    end
  end
`else
  assign w_beat     = w_accept;
  assign w_imm_next = w_used ? se_out : '0;
`endif

  // A prefix accept carries no beat, so a concurrent drain still empties the register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_instr    <= '0;
      r_out_imm      <= '0;
      r_out_imm_used <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_beat) begin
      r_out_valid    <= 1'b1;
      r_out_instr    <= in_instr;
      r_out_imm      <= w_imm_next;
      r_out_imm_used <= w_used;
      r_out_illegal  <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_instr    = r_out_instr;
  assign out_imm      = r_out_imm;
  assign out_imm_used = r_out_imm_used;
  assign out_illegal  = r_out_illegal;

endmodule
